// File: rtl/rr_arbiter4_dec_if.sv
// Bundle of request/grant signals between four requesters and the round-robin arbiter.
// Handshake: a requester holds req[i]=1 until it sees gnt[i]=1, and keeps it high while it
// wants to keep the resource. The owner pulses done for one cycle to hand the resource back.
// gnt is one-hot or zero and is never asserted in the cycle right after another grant ends.
interface rr_arbiter4_dec_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;
  logic [1:0] state_dbg;
  logic [1:0] ptr_dbg;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout, busy, state_dbg, ptr_dbg
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout, busy, state_dbg, ptr_dbg
  );
endinterface

// File: rtl/rr_arbiter4_dec.sv
// Four-way round-robin arbiter with bounded hold time and a forced dead cycle between grants.
// The one-hot grant is a 2-to-4 decode of the registered winner index, enabled by gnt_valid.
module rr_arbiter4_dec #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter4_dec_if.slave bus
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;

  logic [1:0]    winner;
  logic          any_req;
  logic          rel_done, rel_drop, rel_limit;

  // Scan from ptr upward; iterating in reverse leaves the nearest requester as the winner.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign any_req   = |bus.req;
  assign winner    = pick(bus.req, ptr_q);
  assign rel_done  = bus.done;
  assign rel_drop  = ~bus.req[idx_q];
  assign rel_limit = (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      count_q   <= '0;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          count_d = '0;
        end
      end
      GRANT: begin
        valid_d = 1'b1;
        count_d = count_q + 1'b1;
        if (rel_done || rel_drop || rel_limit) begin
          state_d   = GAP;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 2'd1;
          // A limit release that coincides with done or a dropped request is not a timeout.
          timeout_d = rel_limit && !rel_done && !rel_drop;
        end
      end
      GAP: begin
        // ptr_q already points past the previous owner here.
        if (any_req) begin
          state_d = GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Decoder gated by the registered enable, so reset clears gnt without a clock edge.
  always_comb begin
    bus.gnt = 4'b0000;
    if (valid_q) begin
      unique case (idx_q)
        2'd0: bus.gnt = 4'b0001;
        2'd1: bus.gnt = 4'b0010;
        2'd2: bus.gnt = 4'b0100;
        2'd3: bus.gnt = 4'b1000;
        default: bus.gnt = 4'b0000;
      endcase
    end
  end

  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
  assign bus.ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter4_dec.sv
// Self-checking bench for rr_arbiter4_dec: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter4_dec;
  localparam int MAX_HOLD = 8;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rr_arbiter4_dec_if bus ();

  rr_arbiter4_dec #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0=idle, 1=granted, 2=dead slot; held = grant cycles so far.
  int   m_phase, m_owner, m_ptr, m_held;
  logic m_to;
  logic [W-1:0] exp_q[$];

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_step(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_phase == 1) begin
      if (d || !r[m_owner] || m_held == MAX_HOLD) begin
        m_to = (m_held == MAX_HOLD) && !d && r[m_owner];
        m_ptr = (m_owner + 1) % 4;
        m_phase = 2;
      end else begin
        m_held++;
      end
    end else if (r != 4'b0000) begin
      m_owner = first_from(r, m_ptr);
      m_phase = 1;
      m_held = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [W-1:0] m_vec();
    logic [3:0] g;
    g = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_owner), (m_phase == 1), m_to, (m_phase != 0), 2'(m_ptr)};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, bus.busy, bus.ptr_dbg};
  endfunction

  // Driver: apply inputs away from the edge, advance the model, sample 1 time unit after the edge.
  task automatic drive_cycle(input logic [3:0] r, input logic d);
    @(negedge clk);
    bus.req = r;
    bus.done = d;
    m_step(r, d);
    exp_q.push_back(m_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.done = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (act_vec() !== {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL reset_state act=%h exp=%h", act_vec(), {4'b0000, 7'b0});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    apply_reset();
    drive_cycle(4'b0001, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (act_vec() !== e) begin
      bad++;
      $display("FAIL single_model act=%h exp=%h", act_vec(), e);
    end
    total++;
    if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.busy} !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_first_grant gnt=%b idx=%0d valid=%b busy=%b", bus.gnt, bus.gnt_idx,
               bus.gnt_valid, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [W-1:0] e;
    logic [3:0] seq[$];
    logic [3:0] want[5];
    logic [3:0] prev;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    prev = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      drive_cycle(4'b1111, (m_phase == 1) && (m_held == 2));
      e = exp_q.pop_front();
      total++;
      if (act_vec() !== e) begin
        bad++;
        $display("FAIL rotation_model cyc=%0d act=%h exp=%h", c, act_vec(), e);
      end
      if (prev == 4'b0000 && bus.gnt != 4'b0000) seq.push_back(bus.gnt);
      prev = bus.gnt;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= seq.size() || seq[i] !== want[i]) begin
        bad++;
        $display("FAIL rotation_order n=%0d act=%b exp=%b", i, (i < seq.size()) ? seq[i] : 4'bx,
                 want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    int run, tocnt;
    apply_reset();
    run = 0; tocnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(4'b0100, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (act_vec() !== e) begin
        bad++;
        $display("FAIL timeout_model cyc=%0d act=%h exp=%h", c, act_vec(), e);
      end
      if (c < 9 && bus.gnt == 4'b0100) run++;
      if (bus.timeout) tocnt++;
    end
    total++;
    if (run != MAX_HOLD || tocnt != 1 || bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL timeout_limit run=%0d pulses=%0d gnt=%b exp run=%0d pulses=1 gnt=0100",
               run, tocnt, bus.gnt, MAX_HOLD);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    logic [3:0] r[4];
    logic       d[4];
    r = '{4'b1000, 4'b1000, 4'b1001, 4'b1001};
    d = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive_cycle(r[c], d[c]);
      e = exp_q.pop_front();
      total++;
      if (act_vec() !== e) begin
        bad++;
        $display("FAIL wrap_model cyc=%0d act=%h exp=%h", c, act_vec(), e);
      end
    end
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_ptr gnt=%b exp=0001", bus.gnt);
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] e;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive_cycle((c < 3) ? 4'b0010 : 4'b0000, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (act_vec() !== e) begin
        bad++;
        $display("FAIL drop_model cyc=%0d act=%h exp=%h", c, act_vec(), e);
      end
    end
    total++;
    if ({bus.gnt, bus.timeout, bus.ptr_dbg} !== {4'b0000, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL drop_release gnt=%b to=%b ptr=%0d exp gnt=0000 to=0 ptr=2", bus.gnt,
               bus.timeout, bus.ptr_dbg);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    apply_reset();
    drive_cycle(4'b0100, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL midreset_pre gnt=%b exp=0100", bus.gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.gnt_valid, bus.busy} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_async gnt=%b valid=%b busy=%b exp all 0", bus.gnt, bus.gnt_valid,
               bus.busy);
    end
    m_reset();
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(4'b0110, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (act_vec() !== e || bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL midreset_regrant act=%h exp=%h gnt=%b exp gnt=0010", act_vec(), e, bus.gnt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [3:0] prev, r;
    apply_reset();
    prev = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      drive_cycle(r, $urandom_range(0, 4) == 0);
      e = exp_q.pop_front();
      total++;
      if (act_vec() !== e) begin
        bad++;
        $display("FAIL random_model cyc=%0d act=%h exp=%h", c, act_vec(), e);
      end
      total++;
      if ($countones(bus.gnt) > 1 || (prev != 4'b0000 && bus.gnt != 4'b0000 && bus.gnt != prev)) begin
        bad++;
        $display("FAIL random_invariant cyc=%0d gnt=%b prev=%b", c, bus.gnt, prev);
      end
      prev = bus.gnt;
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
